// File: rtl/arcade_input_mapper_if.sv
// Player controls in, active-low cabinet ports out.
// The mapper drives the ports; the source drives the controls.
interface arcade_input_mapper_if;
   logic [10:0] ps2_key;
   logic [15:0] joystk1;
   logic [15:0] joystk2;
   logic        cabinet;
   logic [7:0]  INP0;
   logic [7:0]  INP1;
   logic [7:0]  INP2;

   modport master (
      output ps2_key, joystk1, joystk2, cabinet,
      input  INP0, INP1, INP2
   );

   modport slave (
      input  ps2_key, joystk1, joystk2, cabinet,
      output INP0, INP1, INP2
   );
endinterface

// File: rtl/arcade_input_mapper.sv
// PS/2 keys and joysticks folded into arcade input ports,
// with a fixed-width coin pulse and a mandatory gap.
module arcade_input_mapper #(
   parameter logic [23:0] COIN_PULSE_CYC = 24'd2400000,
   parameter logic [23:0] COIN_GAP_CYC   = 24'd2400000
) (
   input logic             clk_sys,
   input logic             reset,
   arcade_input_mapper_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE, PULSE, GAP, WAIT_REL
   } coin_st_t;

   logic       tog_q;
   logic       key_evt;
   logic       prs;
   logic [8:0] code;

   logic k_up, k_down, k_left, k_right;
   logic k_trig1, k_trig2, k_f1, k_f2;
   logic k_start1, k_start2, k_coin1, k_coin2;
   logic k_left2, k_right2, k_trig21, k_trig22;

   logic left2, right2, trig21, trig22;
   logic left1, right1, trig11, trig12;
   logic start1, start2, creq, merge, coin;

   coin_st_t   state, state_nxt;
   logic [23:0] cnt, cnt_nxt;
   logic        creq_q;

   assign key_evt = bus.ps2_key[10] ^ tog_q;
   assign prs     = bus.ps2_key[9];
   assign code    = bus.ps2_key[8:0];

   // Reset also loads the live toggle, so no event fires after release.
   always_ff @(posedge clk_sys) begin
      tog_q <= bus.ps2_key[10];
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         k_up     <= 1'b0; k_down   <= 1'b0;
         k_left   <= 1'b0; k_right  <= 1'b0;
         k_trig1  <= 1'b0; k_trig2  <= 1'b0;
         k_f1     <= 1'b0; k_f2     <= 1'b0;
         k_start1 <= 1'b0; k_start2 <= 1'b0;
         k_coin1  <= 1'b0; k_coin2  <= 1'b0;
         k_left2  <= 1'b0; k_right2 <= 1'b0;
         k_trig21 <= 1'b0; k_trig22 <= 1'b0;
      end else if (key_evt) begin
         case (1'b1)
            (code[7:0] == 8'h75): k_up     <= prs;
            (code[7:0] == 8'h72): k_down   <= prs;
            (code[7:0] == 8'h6B): k_left   <= prs;
            (code[7:0] == 8'h74): k_right  <= prs;
            (code == 9'h029):     k_trig1  <= prs;
            (code == 9'h014):     k_trig2  <= prs;
            (code == 9'h005):     k_f1     <= prs;
            (code == 9'h006):     k_f2     <= prs;
            (code == 9'h016):     k_start1 <= prs;
            (code == 9'h01E):     k_start2 <= prs;
            (code == 9'h02E):     k_coin1  <= prs;
            (code == 9'h036):     k_coin2  <= prs;
            (code == 9'h023):     k_left2  <= prs;
            (code == 9'h034):     k_right2 <= prs;
            (code == 9'h01C):     k_trig21 <= prs;
            (code == 9'h01B):     k_trig22 <= prs;
            default: ;
         endcase
      end
   end

   assign merge  = ~bus.cabinet;
   assign left2  = k_left2  | bus.joystk2[1];
   assign right2 = k_right2 | bus.joystk2[0];
   assign trig21 = k_trig21 | bus.joystk2[4];
   assign trig22 = k_trig22 | bus.joystk2[5];

   assign left1  = k_left  | bus.joystk1[1]
                 | (merge & left2);
   assign right1 = k_right | bus.joystk1[0]
                 | (merge & right2);
   assign trig11 = k_trig1 | bus.joystk1[4]
                 | (merge & trig21);
   assign trig12 = k_trig2 | bus.joystk1[5]
                 | (merge & trig22);

   assign start1 = k_f1 | k_start1
                 | bus.joystk1[6] | bus.joystk2[6];
   assign start2 = k_f2 | k_start2
                 | bus.joystk1[7] | bus.joystk2[7];
   assign creq   = k_f1 | k_f2 | k_coin1 | k_coin2
                 | bus.joystk1[8] | bus.joystk2[8];

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 24'd0;
         creq_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         creq_q <= creq;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE:
            if (creq && !creq_q) state_nxt = PULSE;
         PULSE:
            if (cnt == COIN_PULSE_CYC - 24'd1)
               state_nxt = GAP;
         GAP:
            if (cnt == COIN_GAP_CYC - 24'd1)
               state_nxt = creq ? WAIT_REL : IDLE;
         WAIT_REL:
            if (!creq) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state)
         cnt_nxt = 24'd0;
      else if (state == PULSE || state == GAP)
         cnt_nxt = cnt + 24'd1;
   end

   assign coin = (state == PULSE);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bus.INP0 <= 8'hFF;
         bus.INP1 <= 8'hFF;
         bus.INP2 <= 8'hFF;
      end else begin
         bus.INP0 <= ~{left1, right1, 3'b0,
                       trig12, trig11, 1'b0};
         bus.INP1 <= ~{left2, right2, 3'b0,
                       trig22, trig21, 1'b0};
         bus.INP2 <= ~{2'b0, start2, start1,
                       3'b0, coin};
      end
   end

   logic unused_bits;
   assign unused_bits = ^{k_up, k_down,
                          bus.joystk1[15:9],
                          bus.joystk1[3:2],
                          bus.joystk2[15:9],
                          bus.joystk2[3:2]};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench: expected port words are queued with a
// due cycle when stimulus is driven and checked on negedge.
module tb_arcade_input_mapper;

   logic clk_sys = 1'b0;
   logic reset;
   always #5 clk_sys = ~clk_sys;

   arcade_input_mapper_if bus ();

   arcade_input_mapper #(
      .COIN_PULSE_CYC (24'd4),
      .COIN_GAP_CYC   (24'd3)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   typedef struct {
      int          cyc;
      string       tag;
      logic [23:0] exp;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   logic tgl      = 1'b0;

   localparam logic [23:0] ALL_FF = 24'hFFFFFF;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check_eq(input string tag,
                           input logic [23:0] got,
                           input logic [23:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input int dly, input string tag,
                          input logic [23:0] v);
      exp_t e;
      e.cyc = cyc + dly;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic sb_rng(input int a, input int b,
                         input string tag,
                         input logic [23:0] v);
      for (int i = a; i <= b; i++) sb_push(i, tag, v);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic key(input logic p, input logic [8:0] c);
      tgl = ~tgl;
      bus.ps2_key = {tgl, p, c};
   endtask

   // Word order is {INP2, INP1, INP0}.
   always @(negedge clk_sys) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check_eq(sb[i].tag,
                     {bus.INP2, bus.INP1, bus.INP0},
                     sb[i].exp);
            sb.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset       = 1'b1;
      bus.ps2_key = 11'd0;
      bus.joystk1 = 16'd0;
      bus.joystk2 = 16'd0;
      bus.cabinet = 1'b0;
      step(1);
      sb_push(0, "rst_hold", ALL_FF);
      step(2);
      sb_push(0, "rst_hold2", ALL_FF);
      reset = 1'b0;
      sb_rng(1, 2, "rst_after", ALL_FF);
      step(3);

      // up key has no port bit
      key(1'b1, 9'h175);
      sb_rng(1, 3, "up_press", ALL_FF);
      step(3);
      key(1'b1, 9'h06B);
      sb_push(1, "left_lat1", ALL_FF);
      sb_push(2, "left_lat2", 24'hFFFF7F);
      step(3);
      key(1'b0, 9'h06B);
      sb_push(1, "left_rel1", 24'hFFFF7F);
      sb_push(2, "left_rel2", ALL_FF);
      step(3);
      key(1'b0, 9'h175);
      sb_push(2, "up_rel", ALL_FF);
      step(3);

      // E0 bit ignored on arrows, required elsewhere
      key(1'b1, 9'h16B);
      sb_push(2, "e0_left", 24'hFFFF7F);
      step(3);
      key(1'b0, 9'h16B);
      sb_push(2, "e0_left_rel", ALL_FF);
      step(3);
      key(1'b1, 9'h129);
      sb_push(2, "e0_trig_unmapped", ALL_FF);
      step(3);
      key(1'b0, 9'h129);
      step(3);

      bus.joystk2 = 16'h0010;
      sb_push(1, "p2trig_upright", 24'hFFFDFD);
      step(2);
      bus.cabinet = 1'b1;
      sb_push(1, "p2trig_cocktail", 24'hFFFDFF);
      step(2);
      bus.joystk2 = 16'd0;
      bus.cabinet = 1'b0;
      sb_push(1, "p2trig_off", ALL_FF);
      step(2);

      key(1'b1, 9'h023);
      sb_push(2, "left2_upright", 24'hFF7F7F);
      step(3);
      bus.cabinet = 1'b1;
      sb_push(1, "left2_cocktail", 24'hFF7FFF);
      step(2);
      key(1'b0, 9'h023);
      bus.cabinet = 1'b0;
      sb_push(2, "left2_rel", ALL_FF);
      step(3);

      // key event and joystick change in one cycle
      key(1'b1, 9'h074);
      bus.joystk1 = 16'h0002;
      sb_push(1, "same_cyc_joy", 24'hFFFF7F);
      sb_push(2, "same_cyc_both", 24'hFFFF3F);
      step(3);
      key(1'b0, 9'h074);
      bus.joystk1 = 16'd0;
      sb_push(1, "same_cyc_rel1", 24'hFFFFBF);
      sb_push(2, "same_cyc_rel2", ALL_FF);
      step(3);

      // one-cycle coin, press in gap ignored
      bus.joystk1 = 16'h0100;
      sb_push(1, "coin1_lat", ALL_FF);
      sb_rng(2, 5, "coin1_pulse", 24'hFEFFFF);
      sb_rng(6, 9, "coin1_gap", ALL_FF);
      step(1);
      bus.joystk1 = 16'd0;
      step(5);
      bus.joystk1 = 16'h0100;
      step(1);
      bus.joystk1 = 16'd0;
      step(1);
      bus.joystk1 = 16'h0100;
      sb_push(1, "coin2_lat", ALL_FF);
      sb_rng(2, 5, "coin2_pulse", 24'hFEFFFF);
      sb_push(6, "coin2_end", ALL_FF);
      step(1);
      bus.joystk1 = 16'd0;
      step(8);

      // held coin gives one pulse until re-press
      bus.joystk1 = 16'h0100;
      sb_push(1, "hold_lat", ALL_FF);
      sb_rng(2, 5, "hold_pulse", 24'hFEFFFF);
      sb_rng(6, 23, "hold_quiet", ALL_FF);
      step(20);
      bus.joystk1 = 16'd0;
      step(2);
      bus.joystk1 = 16'h0100;
      sb_rng(2, 5, "repress_pulse", 24'hFEFFFF);
      sb_push(6, "repress_end", ALL_FF);
      step(1);
      bus.joystk1 = 16'd0;
      step(8);

      // F1 is start1 plus coin
      key(1'b1, 9'h005);
      sb_push(1, "f1_lat", ALL_FF);
      sb_push(2, "f1_start", 24'hEFFFFF);
      sb_rng(3, 6, "f1_pulse", 24'hEEFFFF);
      sb_rng(7, 10, "f1_held", 24'hEFFFFF);
      step(10);
      key(1'b0, 9'h005);
      sb_push(1, "f1_rel1", 24'hEFFFFF);
      sb_rng(2, 5, "f1_rel2", ALL_FF);
      step(6);

      bus.joystk2 = 16'h0080;
      sb_push(1, "p2_start2", 24'hDFFFFF);
      step(2);
      bus.joystk2 = 16'd0;
      sb_push(1, "p2_start2_rel", ALL_FF);
      step(2);

      // reset during pulse with a key toggle
      bus.joystk1 = 16'h0100;
      sb_push(1, "rp_lat", ALL_FF);
      sb_push(2, "rp_pulse", 24'hFEFFFF);
      step(1);
      bus.joystk1 = 16'd0;
      step(1);
      reset = 1'b1;
      key(1'b1, 9'h005);
      sb_rng(1, 2, "rp_in_rst", ALL_FF);
      step(2);
      reset = 1'b0;
      sb_rng(1, 10, "rp_after", ALL_FF);
      step(12);

      check_eq("sb_drain", 24'(sb.size()), 24'd0);
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
